// File: rtl/rasterix_axi_pkg.sv
// Shared AXI read-channel constants and payload structs for the rasterix memory slice.
package rasterix_axi_pkg;

    localparam int unsigned AXI_ID_WIDTH   = 8;
    localparam int unsigned AXI_ADDR_WIDTH = 32;
    localparam int unsigned AXI_DATA_WIDTH = 64;

    localparam logic [1:0] AXI_BURST_FIXED = 2'd0;
    localparam logic [1:0] AXI_BURST_INCR  = 2'd1;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'd2;
    localparam logic [1:0] AXI_BURST_RSVD  = 2'd3;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]   id;
        logic [AXI_ADDR_WIDTH-1:0] addr;
        logic [7:0]                len;
        logic [2:0]                size;
        logic [1:0]                burst;
    } ar_req_t;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]   id;
        logic [AXI_DATA_WIDTH-1:0] data;
        logic [1:0]                resp;
        logic                      last;
    } r_beat_t;

endpackage

// File: rtl/axi_ar_fifo.sv
// Synchronous FIFO holding accepted AR requests until the burst expander takes them.
module axi_ar_fifo
    import rasterix_axi_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         aclk,
    input  logic                         resetn,
    input  logic                         push,
    input  ar_req_t                      push_data,
    input  logic                         pop,
    output ar_req_t                      pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    ar_req_t            mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge aclk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/axi_read_burst_responder.sv
// AXI4 read responder: queues AR bursts, expands them into SRAM word reads and returns R beats.
// Optional feature macro RASTERIX_AXI_WRAP_BURST_EN enables WRAP burst decoding; without it
// every WRAP request is answered as an SLVERR burst with INCR addressing.
module axi_read_burst_responder
    import rasterix_axi_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = AXI_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = AXI_DATA_WIDTH,
    parameter int unsigned ID_WIDTH       = AXI_ID_WIDTH,
    parameter int unsigned MEM_ADDR_WIDTH = 16,
    parameter int unsigned AR_FIFO_DEPTH  = 4
) (
    input  logic                      aclk,
    input  logic                      resetn,
    input  logic [ID_WIDTH-1:0]       arid,
    input  logic [ADDR_WIDTH-1:0]     araddr,
    input  logic [7:0]                arlen,
    input  logic [2:0]                arsize,
    input  logic [1:0]                arburst,
    input  logic                      arvalid,
    output logic                      arready,
    output logic [ID_WIDTH-1:0]       rid,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic [1:0]                rresp,
    output logic                      rlast,
    output logic                      rvalid,
    input  logic                      rready,
    output logic [MEM_ADDR_WIDTH-1:0] memAddr,
    output logic                      memRe,
    input  logic [DATA_WIDTH-1:0]     memRdata,
    output logic                      busy
);

    localparam int unsigned LOG2B = $clog2(DATA_WIDTH / 8);
    localparam int unsigned CNT_W = $clog2(AR_FIFO_DEPTH) + 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    ar_req_t            push_req;
    ar_req_t            pop_req;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W-1:0]   fifo_count_nxt;
    logic               ar_push;

    logic [0:0]         state;
    logic [0:0]         state_nxt;
    logic               issue;
    logic               credit_ok;

    logic [ADDR_WIDTH-1:0] ctx_addr;
    logic [ID_WIDTH-1:0]   ctx_id;
    logic [7:0]            ctx_cnt;
    logic [2:0]            ctx_size;
    logic [1:0]            ctx_mode;
    logic                  ctx_err;
    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] addr_nxt;
`ifdef RASTERIX_AXI_WRAP_BURST_EN
    logic [ADDR_WIDTH-1:0] ctx_mask;
    logic [ADDR_WIDTH-1:0] dec_mask;
`endif

    logic                  dec_wrap_ok;
    logic                  dec_err;
    logic [1:0]            dec_mode;

    logic                  infl_v;
    logic [ID_WIDTH-1:0]   infl_id;
    logic                  infl_last;
    logic [1:0]            infl_resp;

    r_beat_t               in_beat;
    r_beat_t               rbuf0;
    r_beat_t               rbuf1;
    logic [1:0]            rcount;
    logic                  r_pop;

    // Pack the AR channel into the queue payload.
    always_comb begin
        push_req       = '0;
        push_req.id    = arid;
        push_req.addr  = araddr;
        push_req.len   = arlen;
        push_req.size  = arsize;
        push_req.burst = arburst;
    end

    assign ar_push        = arvalid && arready && !fifo_full;
    assign fifo_count_nxt = fifo_count + CNT_W'(ar_push) - CNT_W'(fifo_pop);

    axi_ar_fifo #(
        .DEPTH (AR_FIFO_DEPTH)
    ) u_ar_fifo (
        .aclk      (aclk),
        .resetn    (resetn),
        .push      (ar_push),
        .push_data (push_req),
        .pop       (fifo_pop),
        .pop_data  (pop_req),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // arready follows next-cycle occupancy, so a pop only frees a slot one cycle later.
    always_ff @(posedge aclk) begin
        if (!resetn) arready <= 1'b0;
        else         arready <= (fifo_count_nxt != CNT_W'(AR_FIFO_DEPTH));
    end

    // Classify the request at the head of the queue: error flag and addressing mode.
    always_comb begin
        dec_wrap_ok = 1'b0;
`ifdef RASTERIX_AXI_WRAP_BURST_EN
        dec_wrap_ok = (pop_req.burst == AXI_BURST_WRAP) &&
                      (pop_req.len inside {8'd1, 8'd3, 8'd7, 8'd15});
        dec_mask    = ((ADDR_WIDTH'(pop_req.len) + ADDR_WIDTH'(1)) << pop_req.size) - ADDR_WIDTH'(1);
`endif
        dec_err = (32'(pop_req.size) > LOG2B) ||
                  (pop_req.burst == AXI_BURST_RSVD) ||
                  ((pop_req.burst == AXI_BURST_WRAP) && !dec_wrap_ok);
        if (pop_req.burst == AXI_BURST_FIXED) dec_mode = AXI_BURST_FIXED;
        else if (dec_wrap_ok)                 dec_mode = AXI_BURST_WRAP;
        else                                  dec_mode = AXI_BURST_INCR;
    end

    // Beat issue allowed when in-flight plus buffered beats, after this cycle's drain, leave room.
    assign r_pop     = rvalid && rready;
    assign credit_ok = (3'(infl_v) + 3'(rcount) - 3'(r_pop)) < 3'd2;

    // FSM state register.
    always_ff @(posedge aclk) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // FSM next state: IDLE loads a burst, BURST issues one beat per credited cycle.
    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        issue     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    state_nxt = ST_BURST;
                end
            end
            ST_BURST: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (ctx_cnt == 8'd0) state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign memRe   = issue;
    assign memAddr = ctx_addr[LOG2B +: MEM_ADDR_WIDTH];

    // Next beat address for the active burst.
    always_comb begin
        step     = ADDR_WIDTH'(1) << ctx_size;
        addr_nxt = ctx_addr + step;
        case (ctx_mode)
            AXI_BURST_FIXED: addr_nxt = ctx_addr;
`ifdef RASTERIX_AXI_WRAP_BURST_EN
            AXI_BURST_WRAP:  addr_nxt = (ctx_addr & ~ctx_mask) | ((ctx_addr + step) & ctx_mask);
`endif
            default: begin end
        endcase
    end

    // Burst context: loaded on pop, stepped on every issued beat.
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            ctx_addr <= '0;
            ctx_id   <= '0;
            ctx_cnt  <= '0;
            ctx_size <= '0;
            ctx_mode <= AXI_BURST_INCR;
            ctx_err  <= 1'b0;
`ifdef RASTERIX_AXI_WRAP_BURST_EN
            ctx_mask <= '0;
`endif
        end else if (fifo_pop) begin
            ctx_addr <= pop_req.addr;
            ctx_id   <= pop_req.id;
            ctx_cnt  <= pop_req.len;
            ctx_size <= pop_req.size;
            ctx_mode <= dec_mode;
            ctx_err  <= dec_err;
`ifdef RASTERIX_AXI_WRAP_BURST_EN
            ctx_mask <= dec_mask;
`endif
        end else if (issue) begin
            ctx_addr <= addr_nxt;
            ctx_cnt  <= ctx_cnt - 8'd1;
        end
    end

    // In-flight tag for the beat whose SRAM data arrives next cycle.
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            infl_v    <= 1'b0;
            infl_id   <= '0;
            infl_last <= 1'b0;
            infl_resp <= AXI_RESP_OKAY;
        end else begin
            infl_v <= issue;
            if (issue) begin
                infl_id   <= ctx_id;
                infl_last <= (ctx_cnt == 8'd0);
                infl_resp <= ctx_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            end
        end
    end

    always_comb begin
        in_beat      = '0;
        in_beat.id   = infl_id;
        in_beat.data = memRdata;
        in_beat.resp = infl_resp;
        in_beat.last = infl_last;
    end

    // Two-entry R output buffer; rbuf0 is the presented head.
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            rbuf0  <= '0;
            rbuf1  <= '0;
            rcount <= 2'd0;
        end else begin
            case ({infl_v, r_pop})
                2'b10: begin
                    if (rcount == 2'd0) rbuf0 <= in_beat;
                    else                rbuf1 <= in_beat;
                    rcount <= rcount + 2'd1;
                end
                2'b01: begin
                    rbuf0  <= rbuf1;
                    rcount <= rcount - 2'd1;
                end
                2'b11: begin
                    if (rcount == 2'd1) begin
                        rbuf0 <= in_beat;
                    end else begin
                        rbuf0 <= rbuf1;
                        rbuf1 <= in_beat;
                    end
                end
                default: begin end
            endcase
        end
    end

    assign rvalid = (rcount != 2'd0);
    assign rid    = rbuf0.id;
    assign rdata  = rbuf0.data;
    assign rresp  = rbuf0.resp;
    assign rlast  = rbuf0.last;

    assign busy = !fifo_empty || (state == ST_BURST) || infl_v || (rcount != 2'd0);

endmodule

// File: tb/tb_axi_read_burst_responder.sv
// Scoreboard bench for axi_read_burst_responder with a behavioural SRAM and burst model.
module tb_axi_read_burst_responder;

    logic        aclk = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  arid = '0;
    logic [31:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = '0;
    logic [1:0]  arburst = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [7:0]  rid;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b1;
    logic [15:0] memAddr;
    logic        memRe;
    logic [63:0] memRdata = '0;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;
    int rr_mode  = 1;   // 0: rready low, 1: high, 2: random

    logic [74:0] exp_beat_q[$];
    logic [15:0] exp_addr_q[$];
    logic        hold_v = 1'b0;
    logic [74:0] hold_beat = '0;
    logic [74:0] mon_got;
    logic [74:0] mon_exp;
    logic [15:0] mon_exp_addr;
    logic        mon_have;

    axi_read_burst_responder dut (
        .aclk     (aclk),
        .resetn   (resetn),
        .arid     (arid),
        .araddr   (araddr),
        .arlen    (arlen),
        .arsize   (arsize),
        .arburst  (arburst),
        .arvalid  (arvalid),
        .arready  (arready),
        .rid      (rid),
        .rdata    (rdata),
        .rresp    (rresp),
        .rlast    (rlast),
        .rvalid   (rvalid),
        .rready   (rready),
        .memAddr  (memAddr),
        .memRe    (memRe),
        .memRdata (memRdata),
        .busy     (busy)
    );

    always #5 aclk = ~aclk;

    function automatic logic [63:0] mem_fn(input logic [15:0] a);
        return {a, ~a, a ^ 16'h5a5a, a + 16'h1234};
    endfunction

    // SRAM: one-cycle read latency.
    always @(posedge aclk) begin
        if (memRe) memRdata <= mem_fn(memAddr);
    end

    // R ready pattern.
    always @(posedge aclk) begin
        #1;
        case (rr_mode)
            0:       rready = 1'b0;
            1:       rready = 1'b1;
            default: rready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic check(input string name, input bit ok, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference burst model: addresses and beats straight from the burst rules.
    task automatic exp_burst(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst);
        bit          wrap_ok;
        bit          err;
        logic [31:0] a;
        logic [31:0] mask;
        logic [31:0] step;
        wrap_ok = 1'b0;
`ifdef RASTERIX_AXI_WRAP_BURST_EN
        wrap_ok = (burst == 2'd2) && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
`endif
        err  = (size > 3'd3) || (burst == 2'd3) || (burst == 2'd2 && !wrap_ok);
        step = 32'd1 << size;
        mask = ((32'(len) + 32'd1) << size) - 32'd1;
        a    = addr;
        for (int i = 0; i <= int'(len); i++) begin
            exp_addr_q.push_back(a[18:3]);
            exp_beat_q.push_back({id, (err ? 2'b10 : 2'b00), (i == int'(len)), mem_fn(a[18:3])});
            if (burst == 2'd0)  a = a;
            else if (wrap_ok)   a = (a & ~mask) | ((a + step) & mask);
            else                a = a + step;
        end
    endtask

    // Issue one AR (called just after a posedge); returns just after the accepting edge.
    task automatic send(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
        bit ok;
        exp_burst(id, addr, len, size, burst);
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
        arvalid = 1'b1;
        for (int t = 0; t < 1000; t++) begin
            @(negedge aclk);
            ok = arready;
            @(posedge aclk);
            if (ok) break;
        end
        check("ar_accept", ok, 128'(ok), 128'(1));
        #1 arvalid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 3000; t++) begin
            @(negedge aclk);
            if (exp_beat_q.size() == 0 && !busy) break;
        end
        check("drain", exp_beat_q.size() == 0 && exp_addr_q.size() == 0 && busy == 1'b0,
              128'({busy, 16'(exp_beat_q.size())}), 128'(0));
        @(posedge aclk);
        #1;
    endtask

    // Monitor: SRAM address order, R beats against scoreboard, R stability under stall.
    always @(negedge aclk) begin
        if (!resetn) begin
            hold_v = 1'b0;
        end else begin
            mon_got = {rid, rresp, rlast, rdata};
            if (hold_v)
                check("r_stable", rvalid === 1'b1 && mon_got === hold_beat,
                      128'({rvalid, mon_got}), 128'({1'b1, hold_beat}));
            if (rvalid && rready) begin
                mon_have = exp_beat_q.size() != 0;
                mon_exp  = mon_have ? exp_beat_q.pop_front() : '0;
                check("r_beat", mon_have && mon_got === mon_exp, 128'(mon_got), 128'(mon_exp));
            end
            if (memRe) begin
                mon_have     = exp_addr_q.size() != 0;
                mon_exp_addr = mon_have ? exp_addr_q.pop_front() : '0;
                check("mem_addr", mon_have && memAddr === mon_exp_addr, 128'(memAddr), 128'(mon_exp_addr));
            end
            hold_v    = rvalid && !rready;
            hold_beat = mon_got;
        end
    end

    initial begin
        logic [1:0] b;
        logic [2:0] s;
        logic [7:0] l;

        // Reset values
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_arready", arready === 1'b0, 128'(arready), 128'(0));
        check("rst_rvalid",  rvalid  === 1'b0, 128'(rvalid),  128'(0));
        check("rst_rlast",   rlast   === 1'b0, 128'(rlast),   128'(0));
        check("rst_memre",   memRe   === 1'b0, 128'(memRe),   128'(0));
        check("rst_busy",    busy    === 1'b0, 128'(busy),    128'(0));
        @(posedge aclk);
        #1 resetn = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        check("arready_after_rst", arready === 1'b1, 128'(arready), 128'(1));
        @(posedge aclk);
        #1;

        // INCR with latency probe
        rr_mode = 1;
        send(8'h11, 32'h100, 8'd3, 3'd3, 2'd1);
        @(posedge aclk);
        @(posedge aclk);
        @(negedge aclk);
        check("latency_early", rvalid === 1'b0, 128'(rvalid), 128'(0));
        @(posedge aclk);
        @(negedge aclk);
        check("latency_3", rvalid === 1'b1, 128'(rvalid), 128'(1));
        wait_idle();

        // FIXED, WRAP, error bursts
        send(8'h22, 32'h40, 8'd2, 3'd3, 2'd0);
        wait_idle();
        send(8'h33, 32'h38, 8'd3, 3'd3, 2'd2);
        wait_idle();
        send(8'h44, 32'h200, 8'd1, 3'd4, 2'd1);
        send(8'h45, 32'h300, 8'd0, 3'd2, 2'd3);
        send(8'h46, 32'h400, 8'd2, 3'd3, 2'd2);
        wait_idle();

        // Backpressure on a 16-beat burst
        rr_mode = 2;
        send(8'h55, 32'h1000, 8'd15, 3'd3, 2'd1);
        wait_idle();

        // Queue fill with R stalled
        rr_mode = 0;
        for (int i = 1; i <= 5; i++) send(8'(i), 32'h2000 + 32'(i) * 32'h100, 8'd3, 3'd3, 2'd1);
        repeat (4) @(posedge aclk);
        @(negedge aclk);
        check("queue_full_arready", arready === 1'b0, 128'(arready), 128'(0));
        check("queue_busy", busy === 1'b1, 128'(busy), 128'(1));
        @(posedge aclk);
        #1 rr_mode = 1;
        wait_idle();

        // Randomized back-to-back bursts under random backpressure
        rr_mode = 2;
        for (int i = 0; i < 24; i++) begin
            b = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0) b = 2'd3;
            s = 3'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) s = 3'($urandom_range(4, 7));
            l = 8'($urandom_range(0, 15));
            if (b == 2'd2 && $urandom_range(0, 4) != 0) l = 8'((2 << $urandom_range(0, 3)) - 1);
            send(8'($urandom_range(0, 255)), $urandom(), l, s, b);
        end
        wait_idle();

        // Reset in the middle of an 8-beat burst
        rr_mode = 1;
        send(8'h77, 32'h8000, 8'd7, 3'd3, 2'd1);
        repeat (4) @(posedge aclk);
        #1 resetn = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        check("midrst_rvalid",  rvalid  === 1'b0, 128'(rvalid),  128'(0));
        check("midrst_memre",   memRe   === 1'b0, 128'(memRe),   128'(0));
        check("midrst_arready", arready === 1'b0, 128'(arready), 128'(0));
        check("midrst_busy",    busy    === 1'b0, 128'(busy),    128'(0));
        exp_beat_q.delete();
        exp_addr_q.delete();
        @(posedge aclk);
        #1 resetn = 1'b1;
        @(posedge aclk);
        #1;
        send(8'h78, 32'h9000, 8'd3, 3'd3, 2'd1);
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
